// File: rtl/lvt_mport.sv
// Live-value table: records which write port last wrote each address so a multiport
// RAM wrapper can steer every read port to the bank holding the live value.
module lvt_mport #(
  parameter int unsigned MEMD    = 16,
  parameter int unsigned nRPORTS = 2,
  parameter int unsigned nWPORTS = 2,
  parameter int unsigned RDW     = 0,
  parameter int unsigned RLAT    = 1,
  localparam int unsigned ADDRW  = (MEMD > 1) ? $clog2(MEMD) : 1,
  localparam int unsigned LVTW   = (nWPORTS > 1) ? $clog2(nWPORTS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [nWPORTS-1:0]         WEnb,
  input  logic [ADDRW*nWPORTS-1:0]   WAddr,
  input  logic [nRPORTS-1:0]         REnb,
  input  logic [ADDRW*nRPORTS-1:0]   RAddr,
  output logic [LVTW*nRPORTS-1:0]    RBank,
  output logic [nRPORTS-1:0]         RValid,
  output logic                       Ready,
  output logic                       WConf
);

  localparam logic [ADDRW:0] MemDepth = (ADDRW + 1)'(MEMD);

  logic [LVTW-1:0]          tbl_q [MEMD];
  logic [ADDRW-1:0]         sweep_q;
  logic                     ready_q;
  logic                     wconf_q;
  logic [nWPORTS-1:0]       wvld;
  logic                     conf;
  logic [LVTW*nRPORTS-1:0]  rd;
  logic [nRPORTS-1:0]       rv1_q;
  logic [LVTW*nRPORTS-1:0]  rb1_q;

  // A write counts only when the table is ready and its address is in range.
  always_comb begin
    wvld = '0;
    for (int i = 0; i < nWPORTS; i++) begin
      wvld[i] = ready_q & WEnb[i] & ({1'b0, WAddr[i*ADDRW +: ADDRW]} < MemDepth);
    end
    conf = 1'b0;
    for (int i = 0; i < nWPORTS; i++) begin
      for (int k = i + 1; k < nWPORTS; k++) begin
        if (wvld[i] && wvld[k] && (WAddr[i*ADDRW +: ADDRW] == WAddr[k*ADDRW +: ADDRW])) begin
          conf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_q <= '0;
      ready_q <= 1'b0;
      wconf_q <= 1'b0;
    end else begin
      wconf_q <= conf;
      if (!ready_q) begin
        if (sweep_q == ADDRW'(MEMD - 1)) ready_q <= 1'b1;
        else                             sweep_q <= sweep_q + 1'b1;
      end
    end
  end

  // Ascending port order makes the highest-numbered conflicting port win.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!ready_q) begin
        tbl_q[sweep_q] <= '0;
      end else begin
        for (int i = 0; i < nWPORTS; i++) begin
          if (wvld[i]) tbl_q[WAddr[i*ADDRW +: ADDRW]] <= LVTW'(i);
        end
      end
    end
  end

  always_comb begin
    rd = '0;
    for (int j = 0; j < nRPORTS; j++) begin
      if ({1'b0, RAddr[j*ADDRW +: ADDRW]} < MemDepth) begin
        rd[j*LVTW +: LVTW] = tbl_q[RAddr[j*ADDRW +: ADDRW]];
      end
      if (RDW != 0) begin
        for (int i = 0; i < nWPORTS; i++) begin
          if (wvld[i] && (WAddr[i*ADDRW +: ADDRW] == RAddr[j*ADDRW +: ADDRW])) begin
            rd[j*LVTW +: LVTW] = LVTW'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rv1_q <= '0;
      rb1_q <= '0;
    end else begin
      rv1_q <= REnb & {nRPORTS{ready_q}};
      for (int j = 0; j < nRPORTS; j++) begin
        if (REnb[j] && ready_q) rb1_q[j*LVTW +: LVTW] <= rd[j*LVTW +: LVTW];
      end
    end
  end

  if (RLAT == 2) begin : g_lat2
    logic [nRPORTS-1:0]      rv2_q;
    logic [LVTW*nRPORTS-1:0] rb2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rv2_q <= '0;
        rb2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        for (int j = 0; j < nRPORTS; j++) begin
          if (rv1_q[j]) rb2_q[j*LVTW +: LVTW] <= rb1_q[j*LVTW +: LVTW];
        end
      end
    end

    assign RValid = rv2_q;
    assign RBank  = rb2_q;
  end else begin : g_lat1
    assign RValid = rv1_q;
    assign RBank  = rb1_q;
  end

  assign Ready = ready_q;
  assign WConf = wconf_q;

endmodule

// File: tb/tb_lvt_mport.sv
// Bench for lvt_mport: two instances (RDW=0/RLAT=1 and RDW=1/RLAT=2) share stimulus;
// an array model predicts reads into queues that a monitor drains as RValid appears.
module tb_lvt_mport;
  localparam int MEMD = 12;
  localparam int NR   = 2;
  localparam int NW   = 4;
  localparam int AW   = 4;
  localparam int LW   = 2;
  localparam int MAXC = 8192;

  typedef struct {
    int due;
    int bank;
  } rd_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NW-1:0]     WEnb;
  logic [AW*NW-1:0]  WAddr;
  logic [NR-1:0]     REnb;
  logic [AW*NR-1:0]  RAddr;
  logic [LW*NR-1:0]  RBankA, RBankB;
  logic [NR-1:0]     RValidA, RValidB;
  logic              ReadyA, ReadyB, WConfA, WConfB;

  lvt_mport #(.MEMD(MEMD), .nRPORTS(NR), .nWPORTS(NW), .RDW(0), .RLAT(1)) dut_a (
    .clk(clk), .rst(rst), .WEnb(WEnb), .WAddr(WAddr), .REnb(REnb), .RAddr(RAddr),
    .RBank(RBankA), .RValid(RValidA), .Ready(ReadyA), .WConf(WConfA)
  );

  lvt_mport #(.MEMD(MEMD), .nRPORTS(NR), .nWPORTS(NW), .RDW(1), .RLAT(2)) dut_b (
    .clk(clk), .rst(rst), .WEnb(WEnb), .WAddr(WAddr), .REnb(REnb), .RAddr(RAddr),
    .RBank(RBankB), .RValid(RValidB), .Ready(ReadyB), .WConf(WConfB)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  mem [MEMD];
  int  free  = 0;
  bit  exp_rdy [MAXC];
  bit  exp_wc  [MAXC];
  bit  exp_rst [MAXC];
  rd_t sbq [4][$];
  int  last [4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [AW*NW-1:0] wa4(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic logic [AW*NR-1:0] ra2(input int a0, input int a1);
    return {4'(a1), 4'(a0)};
  endfunction

  // Drive one clock's inputs, predict the effect of the coming edge, wait a cycle.
  task automatic step(input bit r, input logic [NW-1:0] we, input logic [AW*NW-1:0] wa,
                      input logic [NR-1:0] re, input logic [AW*NR-1:0] ra);
    int  e;
    bit  rdy;
    int  nm [MEMD];
    bit  hit [MEMD];
    bit  conf;
    int  a;
    rd_t x;
    e    = cyc + 1;
    rdy  = (free >= MEMD);
    rst  = r;
    WEnb = we;
    WAddr = wa;
    REnb = re;
    RAddr = ra;
    exp_rst[e] = r;
    if (r) begin
      free = 0;
      foreach (mem[i]) mem[i] = 0;
      for (int k = 0; k < 4; k++) sbq[k].delete();
      exp_rdy[e] = 1'b0;
      exp_wc[e]  = 1'b0;
    end else begin
      nm   = mem;
      conf = 1'b0;
      foreach (hit[i]) hit[i] = 1'b0;
      if (rdy) begin
        for (int i = 0; i < NW; i++) begin
          a = int'(wa[i*AW +: AW]);
          if (we[i] && a < MEMD) begin
            if (hit[a]) conf = 1'b1;
            hit[a] = 1'b1;
            nm[a]  = i;
          end
        end
        for (int j = 0; j < NR; j++) begin
          if (re[j]) begin
            a = int'(ra[j*AW +: AW]);
            x.due  = e;
            x.bank = (a < MEMD) ? mem[a] : 0;
            sbq[j].push_back(x);
            x.due  = e + 1;
            x.bank = (a < MEMD) ? nm[a] : 0;
            sbq[2 + j].push_back(x);
          end
        end
      end
      mem = nm;
      free++;
      exp_rdy[e] = (free >= MEMD);
      exp_wc[e]  = conf;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, '0, '0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    bit v;
    int b;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      chk("A.ready", int'(ReadyA), int'(exp_rdy[cyc]));
      chk("B.ready", int'(ReadyB), int'(exp_rdy[cyc]));
      chk("A.wconf", int'(WConfA), int'(exp_wc[cyc]));
      chk("B.wconf", int'(WConfB), int'(exp_wc[cyc]));
      for (int k = 0; k < 4; k++) begin
        if (exp_rst[cyc]) last[k] = 0;
        if (k < 2) begin
          v = RValidA[k];
          b = int'(RBankA[k*LW +: LW]);
        end else begin
          v = RValidB[k-2];
          b = int'(RBankB[(k-2)*LW +: LW]);
        end
        if (sbq[k].size() > 0 && sbq[k][0].due == cyc) begin
          chk($sformatf("rvalid[%0d]", k), int'(v), 1);
          chk($sformatf("rbank[%0d]", k), b, sbq[k][0].bank);
          last[k] = sbq[k][0].bank;
          void'(sbq[k].pop_front());
        end else begin
          chk($sformatf("rvalid_idle[%0d]", k), int'(v), 0);
          chk($sformatf("rbank_hold[%0d]", k), b, last[k]);
        end
      end
    end
  end

  initial begin
    logic [NW-1:0] we;
    logic [NR-1:0] re;
    foreach (last[k]) last[k] = 0;
    repeat (3) step(1'b1, '0, '0, '0, '0);
    // Requests during the sweep must be ignored.
    repeat (MEMD) step(1'b0, 4'b1111, wa4(1, 1, 1, 1), 2'b11, ra2(2, 2));
    step(1'b0, '0, '0, 2'b01, ra2(5, 0));
    step(1'b0, 4'b0010, wa4(0, 3, 0, 0), '0, '0);
    step(1'b0, '0, '0, 2'b01, ra2(3, 0));
    step(1'b0, 4'b0001, wa4(3, 0, 0, 0), '0, '0);
    step(1'b0, '0, '0, 2'b11, ra2(3, 3));
    step(1'b0, 4'b1101, wa4(7, 0, 7, 7), '0, '0);
    step(1'b0, '0, '0, 2'b01, ra2(7, 0));
    step(1'b0, 4'b0010, wa4(0, 9, 0, 0), 2'b01, ra2(9, 0));
    step(1'b0, '0, '0, 2'b01, ra2(9, 0));
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, (i % 2 == 0) ? 2'b11 : 2'b00, ra2(7, 3));
    step(1'b0, 4'b0001, wa4(13, 0, 0, 0), '0, '0);
    step(1'b0, 4'b0011, wa4(13, 13, 0, 0), '0, '0);
    step(1'b0, '0, '0, 2'b11, ra2(13, 7));
    step(1'b0, 4'b1000, wa4(0, 0, 0, 4), '0, '0);
    step(1'b0, '0, '0, 2'b11, ra2(4, 4));
    step(1'b1, '0, '0, 2'b11, ra2(4, 7));
    idle(MEMD);
    step(1'b0, '0, '0, 2'b11, ra2(4, 7));
    idle(3);
    for (int i = 0; i < 1500; i++) begin
      we = NW'($urandom);
      re = NR'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'b1, we, WAddr, re, RAddr);
      end else begin
        step(1'b0, we, wa4($urandom_range(0, 15), $urandom_range(0, 15),
                           $urandom_range(0, 15), $urandom_range(0, 15)),
             re, ra2($urandom_range(0, 15), $urandom_range(0, 15)));
      end
    end
    idle(4);
    for (int k = 0; k < 4; k++) chk($sformatf("drained[%0d]", k), sbq[k].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
